oqpsk_chip_modulator: RTL and testbench
=======================================

Name: oqpsk_chip_modulator

Overview:
- Transmit-side counterpart of the IQ demodulator sample delay line.
- Accepts 4-bit Zigbee data symbols over a valid/ready handshake and spreads each into the 32-chip IEEE 802.15.4 (2.4 GHz) PN sequence.
- Emits half-sine-shaped O-QPSK baseband I/Q samples: 5 samples per chip, Q offset by one chip period (5 samples) from I.
- Feeds the DAC/loopback path; its sample format matches what the receiver delay line consumes.

Parameters:
OUT_W, 5, sample width in bits (signed two's complement); only 5 is supported (pulse LUT is fixed).
SAMPLES_PER_CHIP, 5, samples per chip period; only 5 is supported.

Ports:
clk  in  1  main clock
reset  in  1  asynchronous, active-low reset
sym_in  in  4  data symbol (0..15)
sym_valid  in  1  sym_in is valid
sym_ready  out  1  block can accept a symbol this cycle (combinational)
sample_en  in  1  sample-rate tick; one output sample is produced per tick
i_out  out  OUT_W  in-phase sample, signed
q_out  out  OUT_W  quadrature sample, signed
out_valid  out  1  one-cycle pulse: i_out/q_out were updated this cycle
busy  out  1  high in RUN or TAIL

Behaviour:
- Reset (async, active-low): state=IDLE, cnt=0, i_out=0, q_out=0, out_valid=0, busy=0, held symbol=0, prev_q_chip=0, q_tail_flag=0. Reset mid-symbol aborts the symbol immediately; nothing is flushed.
- Chip table: 16x32 constant taken from the IEEE 802.15.4-2006 O-QPSK chip sequences, with c0 transmitted first.
  - Symbol 0 = 11011001110000110101001000101110 (c0..c31).
  - Even chips c0, c2, ..., c30 go to I; odd chips c1, ..., c31 go to Q.
- Pulse LUT p[k], k=0..9: 2, 7, 11, 13, 15, 15, 13, 11, 7, 2. Chip 1 outputs +p[k]; chip 0 outputs -p[k]. The range ±15 fits OUT_W=5.
- Symbol period is 160 samples. cnt counts 0..159 and advances only on sample_en in RUN.
- State machine: IDLE, RUN, TAIL.
  - IDLE: sym_ready=1. A handshake (sym_valid&sym_ready) latches sym_in, sets cnt=0, clears q_tail_flag and enters RUN. The handshake does not need sample_en.
  - RUN: on each sample_en cycle, registered outputs update on that edge:
    - i_out <= sign(c[2*(cnt/10)]) * p[cnt%10].
    - cnt<5: q_out <= q_tail_flag ? sign(prev_q_chip)*p[cnt+5] : 0.
    - cnt>=5: q_out <= sign(c[2*((cnt-5)/10)+1]) * p[(cnt-5)%10].
    - out_valid <= 1 and cnt <= cnt+1.
  - RUN, at cnt=159: sym_ready = sample_en. On that cycle prev_q_chip <= c31 and q_tail_flag <= 1.
    - If a handshake occurs: latch the new symbol, cnt <= 0, stay in RUN. The Q pulse of c31 continues seamlessly into samples 0..4 of the next symbol.
    - Otherwise: go to TAIL with tcnt=0.
  - TAIL: sym_ready=0. On each sample_en: i_out <= 0, q_out <= sign(prev_q_chip)*p[tcnt+5], out_valid <= 1. After tcnt=4, go to IDLE and clear q_tail_flag.
- Cycles without sample_en: out_valid <= 0 and i_out/q_out hold their values.
- sym_in and sym_valid are ignored while sym_ready=0. The latched symbol is stable for the whole period.
- Frame cost: a single isolated symbol produces exactly 165 out_valid pulses. N back-to-back symbols produce 160*N+5.
- Latency: for a handshake in IDLE at cycle t, the first sample_en at or after t+1 produces sample 0, visible on the following cycle.
- sample_en held high continuously gives one sample per clock; this rate is legal.
- busy is combinational on state: 1 in RUN or TAIL.

Test Plan:
1. Reset, then sym_in=0 with one handshake and sample_en=1 continuously -> I samples 0..9 = +2,+7,+11,+13,+15,+15,+13,+11,+7,+2; I 10..19 = -2,-7,...,-2 (c2=0); Q 0..4 = 0; Q 5..14 = +2..+2 (c1=1); Q 160..164 = -15,-13,-11,-7,-2 with I=0; exactly 165 out_valid pulses, then IDLE and busy=0.
2. Symbols 0 then 0 back-to-back (sym_valid held) -> sym_ready high only on cnt=159 with sample_en; samples 160..164 show I=+2,+7,+11,+13,+15 (new c0) and Q=-15,-13,-11,-7,-2 (previous c31); total 325 pulses.
3. sample_en asserted every 3rd clock -> outputs identical to scenario 1; out_valid pulses are spaced 3 cycles apart; i_out/q_out hold between pulses.
4. Every symbol 0..15 in sequence -> captured I/Q signs decode back to the chip table; no sample lost or duplicated at symbol boundaries.
5. reset pulled low at cnt=73 -> i_out=q_out=0, out_valid=0, sym_ready=1 asynchronously; the next symbol starts cleanly with Q 0..4 = 0.
6. sym_valid high with sym_in toggling while in RUN before cnt=159 -> no handshake occurs; the transmitted sequence matches the originally latched symbol.

Source files
------------

// File: rtl/oqpsk_chip_modulator_if.sv
// Symbol handshake and sample bus of the O-QPSK chip modulator.
// master = symbol source / sample sink, slave = modulator.
interface oqpsk_chip_modulator_if #(
  parameter int unsigned OUT_W = 5
) ();
  logic [3:0]              sym_in;
  logic                    sym_valid;
  logic                    sym_ready;
  logic                    sample_en;
  logic signed [OUT_W-1:0] i_out;
  logic signed [OUT_W-1:0] q_out;
  logic                    out_valid;

  modport master (
    output sym_in, sym_valid, sample_en,
    input  sym_ready, i_out, q_out, out_valid
  );

  modport slave (
    input  sym_in, sym_valid, sample_en,
    output sym_ready, i_out, q_out, out_valid
  );
endinterface

// File: rtl/oqpsk_chip_modulator.sv
// Spreads 4-bit symbols into 802.15.4 32-chip PN sequences and emits half-sine
// O-QPSK I/Q samples (5 per chip, Q delayed one chip period behind I).
module oqpsk_chip_modulator #(
  parameter int unsigned OUT_W            = 5,
  parameter int unsigned SAMPLES_PER_CHIP = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  oqpsk_chip_modulator_if.slave bus,
  output logic                  busy
);

  localparam int unsigned PULSE_LEN = 2 * SAMPLES_PER_CHIP;
  localparam int unsigned SYM_LEN   = 16 * PULSE_LEN;

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0]              tcnt_q, tcnt_d;
  logic [3:0]              sym_q, sym_d;
  logic                    prev_q_chip_q, prev_q_chip_d;
  logic                    q_tail_q, q_tail_d;
  logic signed [OUT_W-1:0] i_q, i_d, q_q, q_d;
  logic                    out_valid_q, out_valid_d;
  logic                    ready;

  logic [0:31] chips;
  logic [7:0]  q_off;
  logic [3:0]  i_chip, i_ph, q_chip, q_ph;

  function automatic logic [0:31] chip_seq(input logic [3:0] s);
    case (s)
      4'd0:    chip_seq = 32'b11011001110000110101001000101110;
      4'd1:    chip_seq = 32'b11101101100111000011010100100010;
      4'd2:    chip_seq = 32'b00101110110110011100001101010010;
      4'd3:    chip_seq = 32'b00100010111011011001110000110101;
      4'd4:    chip_seq = 32'b01010010001011101101100111000011;
      4'd5:    chip_seq = 32'b00110101001000101110110110011100;
      4'd6:    chip_seq = 32'b11000011010100100010111011011001;
      4'd7:    chip_seq = 32'b10011100001101010010001011101101;
      4'd8:    chip_seq = 32'b10001100100101100000011101111011;
      4'd9:    chip_seq = 32'b10111000110010010110000001110111;
      4'd10:   chip_seq = 32'b01111011100011001001011000000111;
      4'd11:   chip_seq = 32'b01110111101110001100100101100000;
      4'd12:   chip_seq = 32'b00000111011110111000110010010110;
      4'd13:   chip_seq = 32'b01100000011101111011100011001001;
      4'd14:   chip_seq = 32'b10010110000001110111101110001100;
      default: chip_seq = 32'b11001001011000000111011110111000;
    endcase
  endfunction

  function automatic logic signed [OUT_W-1:0] shape(input logic chip, input logic [3:0] k);
    logic signed [OUT_W-1:0] p;
    case (k)
      4'd0, 4'd9: p = OUT_W'(2);
      4'd1, 4'd8: p = OUT_W'(7);
      4'd2, 4'd7: p = OUT_W'(11);
      4'd3, 4'd6: p = OUT_W'(13);
      4'd4, 4'd5: p = OUT_W'(15);
      default:    p = '0;
    endcase
    shape = chip ? p : -p;
  endfunction

  assign chips  = chip_seq(sym_q);
  assign i_chip = 4'(cnt_q / 8'(PULSE_LEN));
  assign i_ph   = 4'(cnt_q % 8'(PULSE_LEN));
  assign q_off  = cnt_q - 8'(SAMPLES_PER_CHIP);
  assign q_chip = 4'(q_off / 8'(PULSE_LEN));
  assign q_ph   = 4'(q_off % 8'(PULSE_LEN));

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    tcnt_d        = tcnt_q;
    sym_d         = sym_q;
    prev_q_chip_d = prev_q_chip_q;
    q_tail_d      = q_tail_q;
    i_d           = i_q;
    q_d           = q_q;
    out_valid_d   = 1'b0;
    ready         = 1'b0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.sym_valid) begin
          sym_d    = bus.sym_in;
          cnt_d    = '0;
          q_tail_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        ready = (cnt_q == 8'(SYM_LEN - 1)) && bus.sample_en;
        if (bus.sample_en) begin
          i_d = shape(chips[{i_chip, 1'b0}], i_ph);
          // First half-chip of Q is the tail of the previous symbol's c31 pulse.
          if (cnt_q < 8'(SAMPLES_PER_CHIP))
            q_d = q_tail_q ? shape(prev_q_chip_q, 4'(cnt_q[3:0] + 4'(SAMPLES_PER_CHIP))) : '0;
          else
            q_d = shape(chips[{q_chip, 1'b1}], q_ph);
          out_valid_d = 1'b1;
          cnt_d       = cnt_q + 8'd1;
          if (cnt_q == 8'(SYM_LEN - 1)) begin
            prev_q_chip_d = chips[31];
            q_tail_d      = 1'b1;
            cnt_d         = '0;
            if (bus.sym_valid) begin
              sym_d = bus.sym_in;
            end else begin
              state_d = TAIL;
              tcnt_d  = '0;
            end
          end
        end
      end
      TAIL: begin
        if (bus.sample_en) begin
          i_d         = '0;
          q_d         = shape(prev_q_chip_q, 4'({1'b0, tcnt_q} + 4'(SAMPLES_PER_CHIP)));
          out_valid_d = 1'b1;
          tcnt_d      = tcnt_q + 3'd1;
          if (tcnt_q == 3'(SAMPLES_PER_CHIP - 1)) begin
            state_d  = IDLE;
            q_tail_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      tcnt_q        <= '0;
      sym_q         <= '0;
      prev_q_chip_q <= 1'b0;
      q_tail_q      <= 1'b0;
      i_q           <= '0;
      q_q           <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tcnt_q        <= tcnt_d;
      sym_q         <= sym_d;
      prev_q_chip_q <= prev_q_chip_d;
      q_tail_q      <= q_tail_d;
      i_q           <= i_d;
      q_q           <= q_d;
      out_valid_q   <= out_valid_d;
    end
  end

  assign bus.sym_ready = ready;
  assign bus.i_out     = i_q;
  assign bus.q_out     = q_q;
  assign bus.out_valid = out_valid_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_oqpsk_chip_modulator.sv
// Directed self-checking bench for oqpsk_chip_modulator; expected samples come
// from a chip table rebuilt by rotation/odd-chip inversion of symbol 0.
module tb_oqpsk_chip_modulator;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  bit   rec_all  = 1'b0;

  int cap_i[$], cap_q[$], cap_t[$];
  int all_i[$], all_q[$];
  bit all_v[$];
  int exp_seq[$];

  oqpsk_chip_modulator_if #(.OUT_W(5)) bus ();

  oqpsk_chip_modulator #(.OUT_W(5), .SAMPLES_PER_CHIP(5)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.out_valid) begin
      cap_i.push_back(int'($signed(bus.i_out)));
      cap_q.push_back(int'($signed(bus.q_out)));
      cap_t.push_back(cyc);
    end
    if (rec_all) begin
      all_i.push_back(int'($signed(bus.i_out)));
      all_q.push_back(int'($signed(bus.q_out)));
      all_v.push_back(bus.out_valid);
    end
  end

  function automatic logic [0:31] ref_chips(input int s);
    logic [0:31] base;
    logic [0:31] r;
    base = 32'b11011001110000110101001000101110;
    for (int j = 0; j < 32; j++) r[j] = base[(j - 4 * (s % 8) + 32) % 32];
    if (s >= 8) for (int j = 1; j < 32; j += 2) r[j] = ~r[j];
    return r;
  endfunction

  function automatic int pulse(input int k);
    int p[10];
    p = '{2, 7, 11, 13, 15, 15, 13, 11, 7, 2};
    return p[k];
  endfunction

  function automatic int exp_i(input int n);
    int s, c;
    logic [0:31] ch;
    s = n / 160;
    c = n % 160;
    if (s >= exp_seq.size()) return 0;
    ch = ref_chips(exp_seq[s]);
    return ch[2 * (c / 10)] ? pulse(c % 10) : -pulse(c % 10);
  endfunction

  function automatic int exp_q(input int n);
    int m, s, c;
    logic [0:31] ch;
    m = n - 5;
    if (m < 0) return 0;
    s = m / 160;
    c = m % 160;
    if (s >= exp_seq.size()) return 0;
    ch = ref_chips(exp_seq[s]);
    return ch[2 * (c / 10) + 1] ? pulse(c % 10) : -pulse(c % 10);
  endfunction

  task automatic clear_caps();
    cap_i.delete(); cap_q.delete(); cap_t.delete();
    all_i.delete(); all_q.delete(); all_v.delete();
  endtask

  // Sends syms back-to-back with sym_valid held; sample_en every per-th clock.
  task automatic drive_stream(input int syms[$], input int per,
                              output int hs, output int rdy_run, output bit tmo);
    int idx = 0;
    bit done = 1'b0;
    hs = 0; rdy_run = 0;
    bus.sym_in = 4'(syms[0]);
    bus.sym_valid = 1'b1;
    for (int step = 0; step < 6000 && !done; step++) begin
      bus.sample_en = (step % per == 0);
      #1;
      if (busy && bus.sym_ready) rdy_run++;
      if (bus.sym_valid && bus.sym_ready) begin hs++; idx++; end
      @(negedge clk); #1;
      if (idx >= syms.size()) bus.sym_valid = 1'b0;
      else bus.sym_in = 4'(syms[idx]);
      if (hs == syms.size() && !busy) done = 1'b1;
    end
    bus.sample_en = 1'b0;
    bus.sym_valid = 1'b0;
    tmo = !done;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.sym_in = '0; bus.sym_valid = 1'b0; bus.sample_en = 1'b0;
    #3;
    n_checks++; if (bus.i_out !== 5'sd0) begin n_fail++; $display("FAIL reset_i got %0d want 0", bus.i_out); end
    n_checks++; if (bus.q_out !== 5'sd0) begin n_fail++; $display("FAIL reset_q got %0d want 0", bus.q_out); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (bus.sym_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", bus.sym_ready); end
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_single();
    int s[$]; int hs, rr; bit tmo;
    clear_caps();
    s = {0};
    exp_seq = {0};
    drive_stream(s, 1, hs, rr, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL single_timeout busy still high"); end
    n_checks++; if (cap_i.size() !== 165) begin n_fail++; $display("FAIL single_count got %0d want 165", cap_i.size()); end
    for (int n = 0; n < 165; n++) begin
      n_checks++; if (cap_i[n] !== exp_i(n)) begin n_fail++; $display("FAIL single_i[%0d] got %0d want %0d", n, cap_i[n], exp_i(n)); end
      n_checks++; if (cap_q[n] !== exp_q(n)) begin n_fail++; $display("FAIL single_q[%0d] got %0d want %0d", n, cap_q[n], exp_q(n)); end
    end
    n_checks++; if (cap_i[4] !== 15) begin n_fail++; $display("FAIL single_i4 got %0d want 15", cap_i[4]); end
    n_checks++; if (cap_i[10] !== -2) begin n_fail++; $display("FAIL single_i10 got %0d want -2", cap_i[10]); end
    n_checks++; if (cap_q[5] !== 2) begin n_fail++; $display("FAIL single_q5 got %0d want 2", cap_q[5]); end
    n_checks++; if (cap_q[160] !== -15) begin n_fail++; $display("FAIL single_q160 got %0d want -15", cap_q[160]); end
    n_checks++; if (cap_i[162] !== 0) begin n_fail++; $display("FAIL single_i162 got %0d want 0", cap_i[162]); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
    n_checks++; if (bus.sym_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready_end got %b want 1", bus.sym_ready); end
  endtask

  task automatic test_back_to_back();
    int s[$]; int hs, rr; bit tmo;
    int want_i[5]; int want_q[5];
    want_i = '{2, 7, 11, 13, 15};
    want_q = '{-15, -13, -11, -7, -2};
    clear_caps();
    s = {0, 0};
    exp_seq = {0, 0};
    drive_stream(s, 1, hs, rr, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL b2b_timeout busy still high"); end
    n_checks++; if (hs !== 2) begin n_fail++; $display("FAIL b2b_handshakes got %0d want 2", hs); end
    n_checks++; if (rr !== 2) begin n_fail++; $display("FAIL b2b_ready_in_run got %0d want 2", rr); end
    n_checks++; if (cap_i.size() !== 325) begin n_fail++; $display("FAIL b2b_count got %0d want 325", cap_i.size()); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (cap_i[160 + k] !== want_i[k]) begin n_fail++; $display("FAIL b2b_i[%0d] got %0d want %0d", 160 + k, cap_i[160 + k], want_i[k]); end
      n_checks++; if (cap_q[160 + k] !== want_q[k]) begin n_fail++; $display("FAIL b2b_q[%0d] got %0d want %0d", 160 + k, cap_q[160 + k], want_q[k]); end
    end
    for (int n = 0; n < 325; n++) begin
      n_checks++; if (cap_i[n] !== exp_i(n) || cap_q[n] !== exp_q(n)) begin
        n_fail++; $display("FAIL b2b_iq[%0d] got %0d/%0d want %0d/%0d", n, cap_i[n], cap_q[n], exp_i(n), exp_q(n));
      end
    end
  endtask

  task automatic test_sparse_en();
    int s[$]; int hs, rr; bit tmo;
    bit have; int li, lq;
    clear_caps();
    s = {0};
    exp_seq = {0};
    rec_all = 1'b1;
    drive_stream(s, 3, hs, rr, tmo);
    rec_all = 1'b0;
    n_checks++; if (tmo) begin n_fail++; $display("FAIL sparse_timeout busy still high"); end
    n_checks++; if (cap_i.size() !== 165) begin n_fail++; $display("FAIL sparse_count got %0d want 165", cap_i.size()); end
    n_checks++; if (rr !== 1) begin n_fail++; $display("FAIL sparse_ready_in_run got %0d want 1", rr); end
    for (int n = 0; n < 165; n++) begin
      n_checks++; if (cap_i[n] !== exp_i(n) || cap_q[n] !== exp_q(n)) begin
        n_fail++; $display("FAIL sparse_iq[%0d] got %0d/%0d want %0d/%0d", n, cap_i[n], cap_q[n], exp_i(n), exp_q(n));
      end
      if (n > 0) begin
        n_checks++; if (cap_t[n] - cap_t[n - 1] !== 3) begin n_fail++; $display("FAIL sparse_spacing[%0d] got %0d want 3", n, cap_t[n] - cap_t[n - 1]); end
      end
    end
    have = 1'b0; li = 0; lq = 0;
    for (int n = 0; n < all_v.size(); n++) begin
      if (all_v[n]) begin
        have = 1'b1; li = all_i[n]; lq = all_q[n];
      end else if (have) begin
        n_checks++; if (all_i[n] !== li || all_q[n] !== lq) begin
          n_fail++; $display("FAIL sparse_hold[%0d] got %0d/%0d want %0d/%0d", n, all_i[n], all_q[n], li, lq);
        end
      end
    end
  endtask

  task automatic test_all_symbols();
    int s[$]; int hs, rr; bit tmo;
    logic [0:31] dec;
    clear_caps();
    s.delete();
    for (int k = 0; k < 16; k++) s.push_back(k);
    exp_seq = s;
    drive_stream(s, 1, hs, rr, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL allsym_timeout busy still high"); end
    n_checks++; if (hs !== 16) begin n_fail++; $display("FAIL allsym_handshakes got %0d want 16", hs); end
    n_checks++; if (cap_i.size() !== 2565) begin n_fail++; $display("FAIL allsym_count got %0d want 2565", cap_i.size()); end
    for (int sy = 0; sy < 16; sy++) begin
      for (int j = 0; j < 16; j++) begin
        dec[2 * j]     = (cap_i[sy * 160 + 10 * j + 4] > 0);
        dec[2 * j + 1] = (cap_q[sy * 160 + 5 + 10 * j + 4] > 0);
      end
      n_checks++; if (dec !== ref_chips(sy)) begin n_fail++; $display("FAIL allsym_decode[%0d] got %h want %h", sy, dec, ref_chips(sy)); end
    end
    for (int n = 0; n < 2565; n++) begin
      n_checks++; if (cap_i[n] !== exp_i(n) || cap_q[n] !== exp_q(n)) begin
        n_fail++; $display("FAIL allsym_iq[%0d] got %0d/%0d want %0d/%0d", n, cap_i[n], cap_q[n], exp_i(n), exp_q(n));
      end
    end
  endtask

  task automatic test_reset_midsymbol();
    int s[$]; int hs, rr; bit tmo;
    clear_caps();
    bus.sample_en = 1'b1; bus.sym_in = 4'd0; bus.sym_valid = 1'b1;
    @(negedge clk); #1;
    bus.sym_valid = 1'b0;
    for (int k = 0; k < 300 && cap_i.size() < 73; k++) begin @(negedge clk); #1; end
    n_checks++; if (cap_i.size() !== 73) begin n_fail++; $display("FAIL midrst_reach73 got %0d want 73", cap_i.size()); end
    reset = 1'b0;
    #1;
    n_checks++; if (bus.i_out !== 5'sd0 || bus.q_out !== 5'sd0) begin n_fail++; $display("FAIL midrst_iq got %0d/%0d want 0/0", bus.i_out, bus.q_out); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", bus.out_valid); end
    n_checks++; if (bus.sym_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready got %b want 1", bus.sym_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got %b want 0", busy); end
    bus.sample_en = 1'b0;
    @(negedge clk); #1;
    reset = 1'b1;
    @(negedge clk); #1;
    clear_caps();
    s = {9};
    exp_seq = {9};
    drive_stream(s, 1, hs, rr, tmo);
    n_checks++; if (tmo) begin n_fail++; $display("FAIL midrst_timeout busy still high"); end
    n_checks++; if (cap_i.size() !== 165) begin n_fail++; $display("FAIL midrst_count got %0d want 165", cap_i.size()); end
    for (int k = 0; k < 5; k++) begin
      n_checks++; if (cap_q[k] !== 0) begin n_fail++; $display("FAIL midrst_qhead[%0d] got %0d want 0", k, cap_q[k]); end
    end
    for (int n = 0; n < 165; n++) begin
      n_checks++; if (cap_i[n] !== exp_i(n) || cap_q[n] !== exp_q(n)) begin
        n_fail++; $display("FAIL midrst_iq[%0d] got %0d/%0d want %0d/%0d", n, cap_i[n], cap_q[n], exp_i(n), exp_q(n));
      end
    end
  endtask

  task automatic test_ignore_input();
    int hs = 0;
    bit done = 1'b0;
    clear_caps();
    exp_seq = {3};
    bus.sym_in = 4'd3; bus.sym_valid = 1'b1; bus.sample_en = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      #1;
      if (bus.sym_valid && bus.sym_ready) hs++;
      @(negedge clk); #1;
      bus.sym_in = 4'(k * 7 + 1);
      bus.sym_valid = (cap_i.size() < 150);
      if (hs > 0 && !busy) done = 1'b1;
    end
    bus.sym_valid = 1'b0; bus.sample_en = 1'b0;
    n_checks++; if (!done) begin n_fail++; $display("FAIL ignore_timeout busy still high"); end
    n_checks++; if (hs !== 1) begin n_fail++; $display("FAIL ignore_handshakes got %0d want 1", hs); end
    n_checks++; if (cap_i.size() !== 165) begin n_fail++; $display("FAIL ignore_count got %0d want 165", cap_i.size()); end
    for (int n = 0; n < 165; n++) begin
      n_checks++; if (cap_i[n] !== exp_i(n) || cap_q[n] !== exp_q(n)) begin
        n_fail++; $display("FAIL ignore_iq[%0d] got %0d/%0d want %0d/%0d", n, cap_i[n], cap_q[n], exp_i(n), exp_q(n));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_sparse_en();
    test_all_symbols();
    test_reset_midsymbol();
    test_ignore_input();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
